// File: rtl/panel_axil_master.sv
// panel_axil_master: front-panel pulses to single AXI4-Lite read/write transactions
module panel_axil_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int TIMEOUT = 255,
  parameter int NIB_W = (DATA_W / 4 > 1) ? $clog2(DATA_W / 4) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  nib_load,
  input  logic [NIB_W-1:0]      nib_idx,
  input  logic [3:0]            nib_data,
  input  logic                  submit,
  input  logic                  mode_pulse,
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_W-1:0]     araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [3:0]            disp_nib,
  output logic [3:0]            mode_led,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            err_code
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;

  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] buffer, buffer_nx, wdata_reg, wdata_nx, rdata_reg, rdata_nx;
  logic [ADDR_W-1:0] addr_reg, addr_nx;
  logic [1:0] mode, mode_nx, err_code_nx;
  logic err_nx, awvalid_nx, wvalid_nx, bready_nx, arvalid_nx, rready_nx;

  assign awaddr = addr_reg;
  assign araddr = addr_reg;
  assign wdata = wdata_reg;
  assign wstrb = '1;

  // Display mux: selected nibble of the last read data
  always_comb begin
    disp_nib = '0;
    for (int i = 0; i < DATA_W / 4; i++)
      if (nib_idx == NIB_W'(i)) disp_nib = rdata_reg[4*i +: 4];
  end

  // Next-state and next-output logic: panel inputs, bus handshakes, timeout abort
  always_comb begin
    state_nx = state;
    buffer_nx = buffer;
    addr_nx = addr_reg;
    wdata_nx = wdata_reg;
    rdata_nx = rdata_reg;
    mode_nx = mode;
    err_nx = err;
    err_code_nx = err_code;
    awvalid_nx = 1'b0;
    wvalid_nx = 1'b0;
    bready_nx = 1'b0;
    arvalid_nx = 1'b0;
    rready_nx = 1'b0;
    if (nib_load) begin
      for (int i = 0; i < DATA_W / 4; i++)
        if (nib_idx == NIB_W'(i)) buffer_nx[4*i +: 4] = nib_data;
    end else if (state == IDLE && submit) begin
      case (mode)
        2'd0: begin
          addr_nx = buffer[ADDR_W-1:0];
          buffer_nx = '0;
        end
        2'd1: begin
          wdata_nx = buffer;
          buffer_nx = '0;
        end
        2'd2: begin
          state_nx = RADDR;
          arvalid_nx = 1'b1;
        end
        default: begin
          state_nx = WADDR;
          awvalid_nx = 1'b1;
          wvalid_nx = 1'b1;
        end
      endcase
      if (mode[1]) begin
        err_nx = 1'b0;
        err_code_nx = 2'b00;
      end
    end else if (state == IDLE && mode_pulse) begin
      mode_nx = mode + 2'd1;
    end
    case (state)
      WADDR: begin
        awvalid_nx = awvalid & ~awready;
        wvalid_nx = wvalid & ~wready;
        if (!awvalid_nx && !wvalid_nx) begin
          state_nx = WRESP;
          bready_nx = 1'b1;
        end
      end
      WRESP: begin
        if (bvalid) begin
          state_nx = IDLE;
          err_nx = |bresp;
          err_code_nx = {1'b0, |bresp};
        end else bready_nx = 1'b1;
      end
      RADDR: begin
        if (arready) begin
          state_nx = RDATA;
          rready_nx = 1'b1;
        end else arvalid_nx = 1'b1;
      end
      RDATA: begin
        if (rvalid) begin
          state_nx = IDLE;
          rdata_nx = rdata;
          err_nx = |rresp;
          err_code_nx = {1'b0, |rresp};
        end else rready_nx = 1'b1;
      end
      default: ;
    endcase
    // A phase that makes no progress by its last allowed cycle is abandoned
    if (state != IDLE && state_nx == state && cnt == CNT_W'(TIMEOUT - 1)) begin
      state_nx = IDLE;
      awvalid_nx = 1'b0;
      wvalid_nx = 1'b0;
      bready_nx = 1'b0;
      arvalid_nx = 1'b0;
      rready_nx = 1'b0;
      err_nx = 1'b1;
      err_code_nx = 2'b10;
    end
  end

  // State, datapath and registered outputs; reset abandons any transaction at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      buffer <= '0;
      addr_reg <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      mode <= 2'd0;
      mode_led <= 4'b0001;
      err <= 1'b0;
      err_code <= 2'b00;
      busy <= 1'b0;
      awvalid <= 1'b0;
      wvalid <= 1'b0;
      bready <= 1'b0;
      arvalid <= 1'b0;
      rready <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= (state == IDLE || state_nx != state) ? '0 : cnt + 1'b1;
      buffer <= buffer_nx;
      addr_reg <= addr_nx;
      wdata_reg <= wdata_nx;
      rdata_reg <= rdata_nx;
      mode <= mode_nx;
      mode_led <= 4'd1 << mode_nx;
      err <= err_nx;
      err_code <= err_code_nx;
      busy <= state_nx != IDLE;
      awvalid <= awvalid_nx;
      wvalid <= wvalid_nx;
      bready <= bready_nx;
      arvalid <= arvalid_nx;
      rready <= rready_nx;
    end
  end
endmodule

// File: tb/tb_panel_axil_master.sv
// tb_panel_axil_master: directed vectors with a queue-based transaction scoreboard
module tb_panel_axil_master;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic nib_load, submit, mode_pulse;
  logic [0:0] nib_idx;
  logic [3:0] nib_data;
  logic [7:0] awaddr, araddr, wdata, rdata;
  logic [0:0] wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp, err_code;
  logic [3:0] disp_nib, mode_led;
  logic busy, err;
  int checks = 0;
  int failures = 0;
  int n;
  logic [7:0] exp_addr_q[$];
  logic [7:0] exp_wdata_q[$];
  logic [2:0] exp_done_q[$];
  logic busy_q = 1'b0;

  always #5 clk = ~clk;

  panel_axil_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .nib_load(nib_load), .nib_idx(nib_idx), .nib_data(nib_data),
    .submit(submit), .mode_pulse(mode_pulse),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .disp_nib(disp_nib), .mode_led(mode_led), .busy(busy), .err(err), .err_code(err_code)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [0:0] idx, input logic [3:0] d);
    nib_idx = idx;
    nib_data = d;
    nib_load = 1'b1;
    tick();
    nib_load = 1'b0;
  endtask

  task automatic press_submit();
    submit = 1'b1;
    tick();
    submit = 1'b0;
  endtask

  task automatic press_mode(input logic [3:0] want);
    mode_pulse = 1'b1;
    tick();
    mode_pulse = 1'b0;
    check("mode_led", mode_led, want);
  endtask

  // Monitor: every bus handshake and every transaction completion pops its expectation
  always @(negedge clk) begin
    if (awvalid && awready) begin
      check("aw_expected", exp_addr_q.size() > 0, 1);
      if (exp_addr_q.size() > 0) check("awaddr_hs", awaddr, exp_addr_q.pop_front());
    end
    if (arvalid && arready) begin
      check("ar_expected", exp_addr_q.size() > 0, 1);
      if (exp_addr_q.size() > 0) check("araddr_hs", araddr, exp_addr_q.pop_front());
    end
    if (wvalid && wready) begin
      check("w_expected", exp_wdata_q.size() > 0, 1);
      if (exp_wdata_q.size() > 0) check("wdata_hs", {wstrb, wdata}, {1'b1, exp_wdata_q.pop_front()});
    end
    if (busy_q && !busy && reset_n) begin
      check("done_expected", exp_done_q.size() > 0, 1);
      if (exp_done_q.size() > 0) check("done_err", {err, err_code}, exp_done_q.pop_front());
    end
    busy_q = busy;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    {nib_load, submit, mode_pulse, nib_idx, nib_data} = '0;
    {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata} = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mode_led", mode_led, 4'b0001);
    check("rst_status", {busy, err, err_code}, 0);
    check("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    check("rst_disp", disp_nib, 0);
    reset_n = 1'b1;
    tick();
    // ADDR mode: 0xA3 into addr_reg, buffer cleared
    load(0, 4'h3);
    load(1, 4'hA);
    press_submit();
    check("awaddr", awaddr, 8'hA3);
    check("araddr", araddr, 8'hA3);
    check("mode_addr", mode_led, 4'b0001);
    press_mode(4'b0010);
    press_submit();
    check("wdata_cleared", wdata, 8'h00);
    // nib_load wins over a simultaneous mode_pulse
    nib_idx = 1'b0;
    nib_data = 4'hC;
    nib_load = 1'b1;
    mode_pulse = 1'b1;
    tick();
    {nib_load, mode_pulse} = '0;
    check("mode_hold", mode_led, 4'b0010);
    load(1, 4'h5);
    press_submit();
    check("wdata", wdata, 8'h5C);
    press_mode(4'b0100);
    press_mode(4'b1000);
    press_mode(4'b0001);
    press_mode(4'b0010);
    press_mode(4'b0100);
    press_mode(4'b1000);
    // WRITE 0x5C to 0xA3, awready late, wready immediate
    wready = 1'b1;
    exp_addr_q.push_back(8'hA3);
    exp_wdata_q.push_back(8'h5C);
    exp_done_q.push_back(3'b000);
    press_submit();
    check("wr_start", {busy, awvalid, wvalid, bready}, 4'b1110);
    tick();
    wready = 1'b0;
    check("wr_w_done", {awvalid, wvalid, bready}, 3'b100);
    tick();
    check("wr_aw_wait", {awvalid, bready}, 2'b10);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    check("wr_wresp", {busy, awvalid, wvalid, bready}, 4'b1001);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    check("wr_end", {busy, bready, err, err_code}, 0);
    // READ with slave error response
    press_mode(4'b0001);
    press_mode(4'b0010);
    press_mode(4'b0100);
    arready = 1'b1;
    exp_addr_q.push_back(8'hA3);
    exp_done_q.push_back(3'b101);
    press_submit();
    check("rd_start", {busy, arvalid, rready}, 3'b110);
    tick();
    arready = 1'b0;
    check("rd_rdata", {busy, arvalid, rready}, 3'b101);
    tick();
    check("rd_wait", busy, 1);
    rvalid = 1'b1;
    rdata = 8'hE7;
    rresp = 2'b10;
    tick();
    rvalid = 1'b0;
    check("rd_end", {busy, rready, err, err_code}, 5'b00101);
    nib_idx = 1'b0;
    #1 check("disp_lo", disp_nib, 4'h7);
    nib_idx = 1'b1;
    #1 check("disp_hi", disp_nib, 4'hE);
    // READ timeout with submit and mode_pulse ignored while busy
    exp_done_q.push_back(3'b110);
    press_submit();
    check("to_start", {err, err_code, arvalid}, 4'b0001);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      submit = (i == 3);
      mode_pulse = (i == 5);
      tick();
      if (!arvalid) break;
      n++;
    end
    {submit, mode_pulse} = '0;
    check("to_ar_cycles", n, 16);
    check("to_end", {busy, err, err_code}, 4'b0110);
    check("to_mode", mode_led, 4'b0100);
    // WRITE interrupted by reset while waiting for bvalid
    press_mode(4'b1000);
    awready = 1'b1;
    wready = 1'b1;
    exp_addr_q.push_back(8'hA3);
    exp_wdata_q.push_back(8'h5C);
    press_submit();
    check("rst_wr_clr", {err, err_code}, 0);
    tick();
    check("rst_wr_wresp", {busy, bready}, 2'b11);
    #2 reset_n = 1'b0;
    #1;
    check("async_valids", {busy, awvalid, wvalid, bready, arvalid, rready}, 0);
    check("async_status", {mode_led, err, err_code}, 7'b0001000);
    check("async_disp", disp_nib, 0);
    check("async_addr", awaddr, 0);
    {awready, wready} = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("queues_empty", exp_addr_q.size() + exp_wdata_q.size() + exp_done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
